exec_unit: RTL and testbench
============================

# exec_unit

Parametrised accumulator-based execution unit, successor to the combinational opcode/operand executor. Accepts one opcode/operand pair per cycle over a valid/ready handshake, combines the operand with an internal WIDTH-bit accumulator, and returns the registered result plus status flags one cycle later. Sits between the instruction decoder (upstream) and the register writeback stage (downstream).

## Interface
- WIDTH, 8, data path, accumulator and operand width (≥ 2)
- OPW, 4, opcode width (fixed at 4; parameter for package consistency)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  opcode/operand pair presented
- in_ready  out  1  unit can accept this cycle
- opcode  in  OPW  operation select
- operand  in  WIDTH  operand
- out_valid  out  1  result registers hold an unconsumed result
- out_ready  in  1  downstream consumes result
- result  out  WIDTH  registered result
- flag_z  out  1  result == 0
- flag_c  out  1  carry out (ADD) / borrow (SUB); 0 for other ops
- flag_err  out  1  illegal opcode for this transaction
- acc  out  WIDTH  current accumulator value

## Operation
- Accept when in_valid && in_ready. in_ready = !out_valid || out_ready (single output stage, no skid buffer).
- On accept, res = f(acc, operand) computed combinationally; result, flags and acc update in the same edge.
- Opcode map: 0000 ADD acc+operand; 0001 SUB acc−operand; 0010 AND; 0011 OR; 0100 XOR; 0101 LOAD res=operand; 0110 CLR res=0; 0111 NOP res=acc.
- acc ← res for all legal opcodes (NOP leaves acc unchanged by definition).
- ADD/SUB: computed in WIDTH+1 bits; result = low WIDTH bits, flag_c = bit WIDTH (wrap-around, no saturation). SUB borrow = 1 when operand > acc.
- Illegal opcode (1000–1111, or 1010–1111 with shift enabled): result=0, flag_err=1, flag_z=1, flag_c=0, acc unchanged; transaction still completes normally.
- Output held stable while out_valid && !out_ready. out_valid clears on out_ready with no new accept; stays 1 on simultaneous consume+accept (back-to-back).
- Back-to-back ops chain through acc without bubbles.

## Timing
- Reset values: out_valid=0, result=0, acc=0, flag_z=0, flag_c=0, flag_err=0; in_ready=1 after reset.
- Latency: accept at edge N → result valid from edge N (visible cycle N+1). Throughput 1/cycle when out_ready held high.
- Reset asserted mid-transaction: pending result discarded, all state to reset values immediately; no handshake completes during rst.
- in_valid with in_ready=0: no state change; upstream must hold inputs.

## Configuration
- EXEC_SHIFT_EN defined: opcodes 1000 SHL (acc << operand[$clog2(WIDTH)-1:0], zero fill) and 1001 SHR (logical) are legal; flag_c = last bit shifted out (0 for shift amount 0). Shift amounts ≥ WIDTH impossible by masking.
- Undefined: 1000/1001 are illegal (flag_err=1, result=0, acc unchanged).

## Structure
- Package exec_pkg: opcode localparams/enum (OP_ADD…OP_NOP, OP_SHL, OP_SHR), OPW, flag bundle struct {z, c, err}.
- Sub-module exec_alu: purely combinational (acc, operand, opcode) → (res, flags, legal); exec_unit holds handshake, acc and output registers.

## Test plan
- WIDTH=8: reset, LOAD 0x05, ADD 0x03 → result 0x08, acc 0x08, z=0, c=0.
- acc=0xF0, ADD 0x20 → result 0x10, c=1; then SUB 0x11 → result 0xFF, c=1 (borrow).
- CLR → result 0x00, z=1; opcode 1111 → err=1, result 0, acc unchanged.
- out_ready=0 for 3 cycles after a result: in_ready=0, result stable; stream 4 ops with out_ready=1 → 4 results on consecutive cycles.
- EXEC_SHIFT_EN: acc=0x81, SHL 1 → 0x02, c=1; without macro same opcode → err=1, acc stays 0x81.
- Assert rst while out_valid=1 and out_ready=0 → out_valid, acc, result 0 within the reset cycle.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared opcode encodings and flag bundle for the accumulator execution unit.
// The shift opcodes only become legal when EXEC_SHIFT_EN is defined.
package exec_pkg;

  localparam int OPW = 4;

  typedef enum logic [OPW-1:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_LOAD = 4'h5,
    OP_CLR  = 4'h6,
    OP_NOP  = 4'h7,
    OP_SHL  = 4'h8,
    OP_SHR  = 4'h9
  } op_e;

  typedef struct packed {
    logic z;
    logic c;
    logic err;
  } flags_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational datapath: combines acc with operand under opcode.
// EXEC_SHIFT_EN adds SHL/SHR (opcodes 1000/1001); otherwise they are illegal.
module exec_alu
  import exec_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] operand,
  input  logic [OPW-1:0]   opcode,
  output logic [WIDTH-1:0] res,
  output flags_t           flags,
  output logic             legal
);

  logic [WIDTH:0] wide;
  logic           carry;

`ifdef EXEC_SHIFT_EN
  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  logic [SHW-1:0] sh_amt;
  logic [WIDTH:0] sh_wide;
  assign sh_amt = operand[SHW-1:0];
`endif

  always_comb begin
    res   = '0;
    carry = 1'b0;
    legal = 1'b1;
    wide  = '0;
`ifdef EXEC_SHIFT_EN
    sh_wide = '0;
`endif
    case (opcode)
      OP_ADD: begin
        wide  = {1'b0, acc} + {1'b0, operand};
        res   = wide[WIDTH-1:0];
        carry = wide[WIDTH];
      end
      // The extra top bit of the difference is the borrow (operand > acc).
      OP_SUB: begin
        wide  = {1'b0, acc} - {1'b0, operand};
        res   = wide[WIDTH-1:0];
        carry = wide[WIDTH];
      end
      OP_AND:  res = acc & operand;
      OP_OR:   res = acc | operand;
      OP_XOR:  res = acc ^ operand;
      OP_LOAD: res = operand;
      OP_CLR:  res = '0;
      OP_NOP:  res = acc;
`ifdef EXEC_SHIFT_EN
      // One guard bit on the exit side catches the last bit shifted out.
      OP_SHL: begin
        sh_wide = {1'b0, acc} << sh_amt;
        res     = sh_wide[WIDTH-1:0];
        carry   = sh_wide[WIDTH];
      end
      OP_SHR: begin
        sh_wide = {acc, 1'b0} >> sh_amt;
        res     = sh_wide[WIDTH:1];
        carry   = sh_wide[0];
      end
`endif
      default: legal = 1'b0;
    endcase
    flags.z   = (res == '0);
    flags.c   = carry;
    flags.err = ~legal;
  end

endmodule

// File: rtl/exec_unit.sv
// Accumulator execution unit: valid/ready input, single registered output stage.
// Optional shift opcodes are enabled with the EXEC_SHIFT_EN macro.
module exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW_P = OPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW_P-1:0] opcode,
  input  logic [WIDTH-1:0] operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_err,
  output logic [WIDTH-1:0] acc
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] alu_res;
  flags_t           alu_flags;
  logic             alu_legal;
  logic             accept;

  exec_alu #(.WIDTH(WIDTH)) u_alu (
    .acc     (acc_q),
    .operand (operand),
    .opcode  (opcode[OPW-1:0]),
    .res     (alu_res),
    .flags   (alu_flags),
    .legal   (alu_legal)
  );

  // No skid buffer: a new pair is taken only if the held result leaves this cycle.
  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    acc_d       = acc_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      result_d    = alu_res;
      flags_d     = alu_flags;
      out_valid_d = 1'b1;
      if (alu_legal) acc_d = alu_res;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_z    = flags_q.z;
  assign flag_c    = flags_q.c;
  assign flag_err  = flags_q.err;
  assign acc       = acc_q;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit (WIDTH=8): vector table, hand sequences, random vs model.
module tb_exec_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] opcode = 4'h0;
  logic [7:0] operand = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic       flag_z, flag_c, flag_err;
  logic [7:0] acc;

  int total = 0;
  int bad   = 0;

  exec_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .operand   (operand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_err  (flag_err),
    .acc       (acc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the opcode rules.
  function automatic void model(input int a, input int op, input int opd,
                                output int r, output int z, output int c, output int e);
    int n;
    r = 0; c = 0; e = 0;
    n = opd % 8;
    case (op)
      0: begin r = (a + opd) % 256; c = (a + opd > 255) ? 1 : 0; end
      1: begin r = (a - opd + 256) % 256; c = (opd > a) ? 1 : 0; end
      2: r = a & opd;
      3: r = a | opd;
      4: r = a ^ opd;
      5: r = opd;
      6: r = 0;
      7: r = a;
`ifdef EXEC_SHIFT_EN
      8: begin r = (a * (1 << n)) % 256; c = (n == 0) ? 0 : (a / (1 << (8 - n))) % 2; end
      9: begin r = a / (1 << n); c = (n == 0) ? 0 : (a / (1 << (n - 1))) % 2; end
`endif
      default: e = 1;
    endcase
    z = (r == 0) ? 1 : 0;
  endfunction

  typedef struct {
    logic [3:0] op;
    logic [7:0] opd;
    logic [7:0] r;
    logic       z, c, e;
    logic [7:0] a;
  } vec_t;

  vec_t vecs[16];
  int   nvec;

  task automatic add_vec(input logic [3:0] op, input logic [7:0] opd, input logic [7:0] r,
                         input logic z, input logic c, input logic e, input logic [7:0] a);
    vecs[nvec] = '{op, opd, r, z, c, e, a};
    nvec++;
  endtask

  initial begin
    int mr, mz, mc, me, macc, mv, exp_ready;
    logic [7:0] held;
    logic       iv, ordy;
    logic [3:0] op;
    logic [7:0] opd;

    nvec = 0;
    add_vec(4'h5, 8'h05, 8'h05, 0, 0, 0, 8'h05);
    add_vec(4'h0, 8'h03, 8'h08, 0, 0, 0, 8'h08);
    add_vec(4'h5, 8'hF0, 8'hF0, 0, 0, 0, 8'hF0);
    add_vec(4'h0, 8'h20, 8'h10, 0, 1, 0, 8'h10);
    add_vec(4'h1, 8'h11, 8'hFF, 0, 1, 0, 8'hFF);
    add_vec(4'h6, 8'h77, 8'h00, 1, 0, 0, 8'h00);
    add_vec(4'h5, 8'h81, 8'h81, 0, 0, 0, 8'h81);
    add_vec(4'hF, 8'h12, 8'h00, 1, 0, 1, 8'h81);
`ifdef EXEC_SHIFT_EN
    add_vec(4'h8, 8'h01, 8'h02, 0, 1, 0, 8'h02);
`else
    add_vec(4'h8, 8'h01, 8'h00, 1, 0, 1, 8'h81);
`endif
    add_vec(4'h5, 8'h3C, 8'h3C, 0, 0, 0, 8'h3C);
    add_vec(4'h2, 8'h0F, 8'h0C, 0, 0, 0, 8'h0C);
    add_vec(4'h3, 8'h41, 8'h4D, 0, 0, 0, 8'h4D);
    add_vec(4'h4, 8'hFF, 8'hB2, 0, 0, 0, 8'hB2);
    add_vec(4'h7, 8'h00, 8'hB2, 0, 0, 0, 8'hB2);
    add_vec(4'h1, 8'hB2, 8'h00, 1, 0, 0, 8'h00);
    add_vec(4'h1, 8'h01, 8'hFF, 0, 1, 0, 8'hFF);

    // Reset values
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_result", {24'd0, result}, 0);
    chk("rst_acc", {24'd0, acc}, 0);
    chk("rst_flags", {29'd0, flag_z, flag_c, flag_err}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 1);

    // Table vectors, streamed back-to-back with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < nvec; i++) begin
      in_valid = 1'b1; opcode = vecs[i].op; operand = vecs[i].opd;
      @(posedge clk); #1;
      $display("vec %0d op=%h opd=%h -> res=%h z=%b c=%b e=%b acc=%h", i, vecs[i].op,
               vecs[i].opd, result, flag_z, flag_c, flag_err, acc);
      chk("vec_valid", {31'd0, out_valid}, 1);
      chk("vec_result", {24'd0, result}, {24'd0, vecs[i].r});
      chk("vec_flags", {29'd0, flag_z, flag_c, flag_err}, {29'd0, vecs[i].z, vecs[i].c, vecs[i].e});
      chk("vec_acc", {24'd0, acc}, {24'd0, vecs[i].a});
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_valid", {31'd0, out_valid}, 0);

    // Backpressure: hold a result for 3 cycles with a waiting request
    out_ready = 1'b0;
    in_valid = 1'b1; opcode = 4'h5; operand = 8'h11;
    @(posedge clk); #1;
    held = result;
    chk("bp_first", {24'd0, result}, 32'h11);
    opcode = 4'h0; operand = 8'h22;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready", {31'd0, in_ready}, 0);
      @(posedge clk); #1;
      $display("bp cycle %0d: out_valid=%b result=%h acc=%h", k, out_valid, result, acc);
      chk("bp_valid", {31'd0, out_valid}, 1);
      chk("bp_result", {24'd0, result}, {24'd0, held});
      chk("bp_acc", {24'd0, acc}, 32'h11);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 1);
    @(posedge clk); #1;
    chk("bp_release_result", {24'd0, result}, 32'h33);

    // Reset while a result is held
    out_ready = 1'b0;
    opcode = 4'h5; operand = 8'h55;
    @(posedge clk); #1;
    chk("prerst_valid", {31'd0, out_valid}, 1);
    #2 rst = 1'b1;
    #1;
    $display("midrst: out_valid=%b result=%h acc=%h", out_valid, result, acc);
    chk("midrst_valid", {31'd0, out_valid}, 0);
    chk("midrst_acc", {24'd0, acc}, 0);
    chk("midrst_result", {24'd0, result}, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst_hold", {31'd0, out_valid}, 0);
    rst = 1'b0;

    // Randomized traffic against the model
    macc = 0; mv = 0; mr = 0; mz = 0; mc = 0; me = 0;
    for (int t = 0; t < 300; t++) begin
      int nr, nz, nc, ne;
      iv = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      op = 4'($urandom_range(0, 15));
      opd = 8'($urandom_range(0, 255));
      in_valid = iv; out_ready = ordy; opcode = op; operand = opd;
      #1;
      exp_ready = (mv == 0 || ordy) ? 1 : 0;
      chk("rnd_in_ready", {31'd0, in_ready}, exp_ready);
      @(posedge clk); #1;
      if (iv && exp_ready == 1) begin
        model(macc, int'(op), int'(opd), nr, nz, nc, ne);
        mr = nr; mz = nz; mc = nc; me = ne; mv = 1;
        if (ne == 0) macc = nr;
      end else if (ordy) begin
        mv = 0;
      end
      $display("rnd %0d iv=%b ordy=%b op=%h opd=%h -> ov=%b res=%h zce=%b%b%b acc=%h",
               t, iv, ordy, op, opd, out_valid, result, flag_z, flag_c, flag_err, acc);
      chk("rnd_valid", {31'd0, out_valid}, mv);
      chk("rnd_acc", {24'd0, acc}, macc);
      if (mv == 1) begin
        chk("rnd_result", {24'd0, result}, mr);
        chk("rnd_flags", {29'd0, flag_z, flag_c, flag_err}, (mz << 2) | (mc << 1) | me);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
